osw_switch_ctrl_n: RTL and testbench
====================================

OSW_SWITCH_CTRL_N -- requirements
Module: osw_switch_ctrl_n

Interface
REQ-001 SHALL have parameter C_NUM_CH, default 2: optical switch channels, legal range 1-16.
REQ-002 SHALL have parameter C_SETTLE_CYCLES, default 8: wait after drive change before checking status, legal range 0-255.
REQ-003 SHALL have parameter C_TIMEOUT_CYCLES, default 64: maximum CHECK cycles before timeout, legal range 1-65535.
REQ-004 SHALL use one clock and a synchronous, active-high reset: S_AXI_ACLK in 1, all logic on its rising edge.
REQ-005 S_AXI_ARESET  in  1  synchronous active-high reset.
REQ-006 S_AXI_AWADDR  in  32  write address; bits [3:2] decoded, all other bits ignored.
REQ-007 S_AXI_AWVALID in 1 / S_AXI_AWREADY out 1: write address handshake.
REQ-008 S_AXI_WDATA in 32 / S_AXI_WVALID in 1 / S_AXI_WREADY out 1: write data handshake.
REQ-009 S_AXI_BRESP out 2 (always 0) / S_AXI_BVALID out 1 / S_AXI_BREADY in 1: write response.
REQ-010 S_AXI_ARADDR in 32 / S_AXI_ARVALID in 1 / S_AXI_ARREADY out 1: read address handshake.
REQ-011 S_AXI_RDATA out 32 / S_AXI_RRESP out 2 (always 0) / S_AXI_RVALID out 1 / S_AXI_RREADY in 1: read data.
REQ-012 common_rst out 1: one-cycle reset pulse to downstream tx logic at the start of each switch.
REQ-013 common_gate out 1: tx enable; high only after a verified switch.
REQ-014 switch_on out 1: one-cycle pulse when the drive pattern changes.
REQ-015 switch_done out 1: one-cycle pulse on verified completion.
REQ-016 osw_drive out C_NUM_CH: switch driver outputs.
REQ-017 osw_status in C_NUM_CH: switch position feedback, asynchronous.

Function
REQ-018 Register map: 0x0 CTRL (write bit0 START, bit1 ABORT; both self-clearing pulses; reads 0); 0x4 TARGET (R/W, [C_NUM_CH-1:0], upper bits read 0); 0x8 STATUS (read-only: bit0 busy, bit1 done, bit2 timeout, [15:8] switch count); 0xC OSW (read-only, sampled osw_status).
REQ-019 Write handshake: AWREADY and WREADY both high for exactly one cycle when AWVALID=WVALID=1 and BVALID=0; BVALID then set next cycle and held until BREADY=1.
REQ-020 Read handshake: ARREADY high for one cycle when ARVALID=1 and RVALID=0; RDATA registered with RVALID the next cycle and held until RREADY=1.
REQ-021 A read in the same cycle as a write to the same register SHALL return the pre-write value.
REQ-022 FSM states: IDLE, RST, DRIVE, SETTLE, CHECK, DONE, ERR.
REQ-023 IDLE: on START (write handshake at cycle T) go to RST at T+1, clear the done and timeout bits, and drive common_gate=0.
REQ-024 RST: common_rst=1 for exactly one cycle, then DRIVE.
REQ-025 DRIVE: osw_drive takes TARGET on entry; switch_on=1 for one cycle; load the settle counter; go to SETTLE, or to CHECK if C_SETTLE_CYCLES=0.
REQ-026 SETTLE: decrement once per cycle; after C_SETTLE_CYCLES cycles go to CHECK.
REQ-027 CHECK: when sampled status equals osw_drive, go to DONE; otherwise count, and after C_TIMEOUT_CYCLES mismatching cycles go to ERR.
REQ-028 DONE (one cycle): switch_done=1, common_gate=1, set done, increment the switch count (8-bit, wraps 255 to 0), go to IDLE.
REQ-029 ERR (one cycle): set timeout, keep osw_drive unchanged, keep common_gate=0, go to IDLE.
REQ-030 busy=1 in every state except IDLE.
REQ-031 START while busy SHALL be ignored.
REQ-032 ABORT in any non-IDLE state returns the FSM to IDLE the next cycle, with osw_drive held, done and timeout unchanged, and common_gate=0.
REQ-033 START and ABORT set in the same write: ABORT wins and no switch starts.
REQ-034 A TARGET write while busy updates the register but does not affect the switch in progress.

Reset
REQ-035 S_AXI_ARESET=1 SHALL, at the next edge, clear every register and output to 0 (osw_drive, TARGET, STATUS, common_*, switch_*, all READY/VALID signals) and put the FSM in IDLE, including mid-operation.

Configuration
REQ-036 Macro OSW_STATUS_SYNC_EN defined: osw_status passes through a two-flop synchronizer per bit before CHECK and OSW use it, adding 2 cycles of sampling delay. Macro undefined: osw_status is used directly.

Verification
REQ-037 C_NUM_CH=4, C_SETTLE_CYCLES=4, osw_status tied to osw_drive; write TARGET=0xA, then START at T -> common_rst at T+1, osw_drive=0xA and switch_on at T+2, switch_done at T+8, STATUS reads 0x0102, common_gate=1.
REQ-038 osw_status tied to 0, TARGET=0x5, C_TIMEOUT_CYCLES=16 -> no switch_done; STATUS bit2=1 after 16 CHECK cycles; common_gate=0; busy=0.
REQ-039 ABORT written during SETTLE -> IDLE next cycle, no switch_done, STATUS bit1 and bit2 both 0, osw_drive keeps its new value.
REQ-040 Second START while busy, then START+ABORT in IDLE -> exactly one switch_done and switch count=1.
REQ-041 S_AXI_ARESET pulsed during CHECK -> all outputs 0 next cycle and TARGET reads 0.
REQ-042 C_SETTLE_CYCLES=0 with loopback -> switch_done at T+4 without OSW_STATUS_SYNC_EN and at T+5 with it.

Source files
------------

// File: rtl/osw_switch_ctrl_n_if.sv
// osw_switch_ctrl_n_if: AXI4-Lite register bus for the optical switch controller
interface osw_switch_ctrl_n_if;
  logic [31:0] S_AXI_AWADDR;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [31:0] S_AXI_ARADDR;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WVALID, S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WVALID, S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/osw_switch_ctrl_n.sv
// osw_switch_ctrl_n: AXI-Lite driven optical switch sequencer; define OSW_STATUS_SYNC_EN to add a 2-flop osw_status synchronizer
module osw_switch_ctrl_n #(
  parameter int C_NUM_CH         = 2,
  parameter int C_SETTLE_CYCLES  = 8,
  parameter int C_TIMEOUT_CYCLES = 64
) (
  input  logic                S_AXI_ACLK,
  input  logic                S_AXI_ARESET,
  osw_switch_ctrl_n_if.slave  s_axi,
  output logic                common_rst,
  output logic                common_gate,
  output logic                switch_on,
  output logic                switch_done,
  output logic [C_NUM_CH-1:0] osw_drive,
  input  logic [C_NUM_CH-1:0] osw_status
);
  typedef enum logic [2:0] {IDLE, RST, DRIVE, SETTLE, CHECK, DONE, ERR} state_t;
  localparam logic [15:0] SL = 16'(C_SETTLE_CYCLES == 0 ? 0 : C_SETTLE_CYCLES - 1);
  localparam logic [15:0] TL = 16'(C_TIMEOUT_CYCLES - 1);
  state_t state, nxt;
  logic [C_NUM_CH-1:0] target, sts;
  logic [15:0] cnt;
  logic [7:0] sw_cnt;
  logic [31:0] rdata, rd_mux;
  logic aw_rdy, bvalid, ar_rdy, rvalid;
  logic done_q, tmo_q, gate_q, busy;
  logic wr_go, rd_go, ctrl_wr, start, abort;
  logic unused_bits;
  assign unused_bits = ^{s_axi.S_AXI_AWADDR, s_axi.S_AXI_ARADDR, s_axi.S_AXI_WDATA};
  assign wr_go = aw_rdy && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID;
  assign rd_go = ar_rdy && s_axi.S_AXI_ARVALID;
  assign ctrl_wr = wr_go && s_axi.S_AXI_AWADDR[3:2] == 2'd0;
  assign start = ctrl_wr && s_axi.S_AXI_WDATA[0];
  assign abort = ctrl_wr && s_axi.S_AXI_WDATA[1];
  assign s_axi.S_AXI_AWREADY = aw_rdy;
  assign s_axi.S_AXI_WREADY = aw_rdy;
  assign s_axi.S_AXI_BVALID = bvalid;
  assign s_axi.S_AXI_BRESP = 2'b00;
  assign s_axi.S_AXI_ARREADY = ar_rdy;
  assign s_axi.S_AXI_RVALID = rvalid;
  assign s_axi.S_AXI_RDATA = rdata;
  assign s_axi.S_AXI_RRESP = 2'b00;
  assign common_gate = gate_q;
`ifdef OSW_STATUS_SYNC_EN
  logic [C_NUM_CH-1:0] sync1;
  // two-flop synchronizer for the asynchronous switch feedback
  always_ff @(posedge S_AXI_ACLK) begin
    sync1 <= S_AXI_ARESET ? '0 : osw_status;
    sts <= S_AXI_ARESET ? '0 : sync1;
  end
`else
  assign sts = osw_status;
`endif
  // FSM state register
  always_ff @(posedge S_AXI_ACLK) begin
    state <= S_AXI_ARESET ? IDLE : nxt;
  end
  // next state: abort beats everything once a switch is in flight
  always_comb begin
    nxt = state;
    if (abort && state != IDLE) nxt = IDLE;
    else
      case (state)
        IDLE:    nxt = (start && !abort) ? RST : IDLE;
        RST:     nxt = DRIVE;
        DRIVE:   nxt = (C_SETTLE_CYCLES == 0) ? CHECK : SETTLE;
        SETTLE:  nxt = (cnt == 16'd0) ? CHECK : SETTLE;
        CHECK:   nxt = (sts == osw_drive) ? DONE : (cnt == TL) ? ERR : CHECK;
        default: nxt = IDLE;
      endcase
  end
  // state-decoded strobes
  always_comb begin
    busy = state != IDLE;
    common_rst = state == RST;
    switch_on = state == DRIVE;
    switch_done = state == DONE;
  end
  // switch datapath: drive latch, settle/timeout counter, status bits
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      osw_drive <= '0;
      target <= '0;
      cnt <= '0;
      sw_cnt <= '0;
      done_q <= 1'b0;
      tmo_q <= 1'b0;
      gate_q <= 1'b0;
    end else begin
      osw_drive <= (state == RST && nxt == DRIVE) ? target : osw_drive;
      target <= (wr_go && s_axi.S_AXI_AWADDR[3:2] == 2'd1) ? s_axi.S_AXI_WDATA[C_NUM_CH-1:0] : target;
      cnt <= (state == DRIVE) ? SL : (state == SETTLE && cnt != 16'd0) ? cnt - 16'd1 : (state == CHECK) ? cnt + 16'd1 : '0;
      sw_cnt <= sw_cnt + 8'(nxt == DONE);
      done_q <= (nxt == DONE) || (done_q && nxt != RST);
      tmo_q <= (nxt == ERR) || (tmo_q && nxt != RST);
      gate_q <= (nxt == DONE) || (gate_q && nxt == IDLE && !(abort && busy));
    end
  end
  // read mux sampled before any same-cycle write lands
  always_comb begin
    rd_mux = (s_axi.S_AXI_ARADDR[3:2] == 2'd0) ? 32'd0 :
             (s_axi.S_AXI_ARADDR[3:2] == 2'd1) ? 32'(target) :
             (s_axi.S_AXI_ARADDR[3:2] == 2'd2) ? {16'd0, sw_cnt, 5'd0, tmo_q, done_q, busy} : 32'(sts);
  end
  // AXI-Lite handshakes: single-cycle ready, response held until accepted
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      aw_rdy <= 1'b0;
      bvalid <= 1'b0;
      ar_rdy <= 1'b0;
      rvalid <= 1'b0;
      rdata <= '0;
    end else begin
      aw_rdy <= !aw_rdy && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID && !bvalid;
      bvalid <= wr_go || (bvalid && !s_axi.S_AXI_BREADY);
      ar_rdy <= !ar_rdy && s_axi.S_AXI_ARVALID && !rvalid;
      rvalid <= rd_go || (rvalid && !s_axi.S_AXI_RREADY);
      rdata <= rd_go ? rd_mux : rdata;
    end
  end
endmodule

// File: tb/tb_osw_switch_ctrl_n.sv
// tb_osw_switch_ctrl_n: directed checks of the switch sequencer (settle=4 unit plus a settle=0 unit)
module tb_osw_switch_ctrl_n;
  logic clk = 0, rst = 1, loop = 0;
  always #5 clk = ~clk;
  osw_switch_ctrl_n_if ifa(), ifb();
  logic [3:0] drv_a, drv_b, sts_a;
  logic crst_a, gate_a, on_a, done_a, crst_b, gate_b, on_b, done_b;
  assign sts_a = loop ? drv_a : 4'h0;
  assign ifb.S_AXI_AWADDR = ifa.S_AXI_AWADDR;
  assign ifb.S_AXI_AWVALID = ifa.S_AXI_AWVALID;
  assign ifb.S_AXI_WDATA = ifa.S_AXI_WDATA;
  assign ifb.S_AXI_WVALID = ifa.S_AXI_WVALID;
  assign ifb.S_AXI_BREADY = ifa.S_AXI_BREADY;
  assign ifb.S_AXI_ARADDR = ifa.S_AXI_ARADDR;
  assign ifb.S_AXI_ARVALID = ifa.S_AXI_ARVALID;
  assign ifb.S_AXI_RREADY = ifa.S_AXI_RREADY;
  osw_switch_ctrl_n #(.C_NUM_CH(4), .C_SETTLE_CYCLES(4), .C_TIMEOUT_CYCLES(16)) dut_a (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .s_axi(ifa),
    .common_rst(crst_a), .common_gate(gate_a), .switch_on(on_a), .switch_done(done_a),
    .osw_drive(drv_a), .osw_status(sts_a));
  osw_switch_ctrl_n #(.C_NUM_CH(4), .C_SETTLE_CYCLES(0), .C_TIMEOUT_CYCLES(16)) dut_b (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .s_axi(ifb),
    .common_rst(crst_b), .common_gate(gate_b), .switch_on(on_b), .switch_done(done_b),
    .osw_drive(drv_b), .osw_status(drv_b));
`ifdef OSW_STATUS_SYNC_EN
  localparam int BEXP = 5;
`else
  localparam int BEXP = 4;
`endif
  int cyc = 0, checks = 0, errors = 0, na = 0, nb = 0;
  int done_cyc = -1, bdone_cyc = -1, rst_cyc = -1, on_cyc = -1;
  logic [3:0] on_drv = '0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (!rst) begin
      if (done_a) begin na++; done_cyc = cyc; end
      if (done_b) begin nb++; bdone_cyc = cyc; end
      if (crst_a) rst_cyc = cyc;
      if (on_a) begin on_cyc = cyc; on_drv = drv_a; end
    end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, output int t);
    ifa.S_AXI_AWADDR = a;
    ifa.S_AXI_WDATA = d;
    ifa.S_AXI_AWVALID = 1;
    ifa.S_AXI_WVALID = 1;
    t = -1;
    for (int i = 0; i < 20 && t < 0; i++) begin
      @(negedge clk);
      if (ifa.S_AXI_AWREADY) t = cyc;
    end
    check("wr_accept", 32'(t >= 0), 32'd1);
    @(posedge clk);
    #1;
    ifa.S_AXI_AWVALID = 0;
    ifa.S_AXI_WVALID = 0;
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    int t;
    ifa.S_AXI_ARADDR = a;
    ifa.S_AXI_ARVALID = 1;
    t = -1;
    for (int i = 0; i < 20 && t < 0; i++) begin
      @(negedge clk);
      if (ifa.S_AXI_ARREADY) t = cyc;
    end
    check("rd_accept", 32'(t >= 0), 32'd1);
    @(posedge clk);
    #1;
    ifa.S_AXI_ARVALID = 0;
    @(negedge clk);
    check("rvalid", 32'(ifa.S_AXI_RVALID), 32'd1);
    d = ifa.S_AXI_RDATA;
  endtask
  task automatic wait_done(input int n0);
    for (int i = 0; i < 40 && na <= n0; i++) @(negedge clk);
    check("done_seen", 32'(na > n0), 32'd1);
  endtask
  initial begin
    logic [31:0] d;
    int t, t0, t1, n0;
    ifa.S_AXI_AWADDR = 0; ifa.S_AXI_AWVALID = 0; ifa.S_AXI_WDATA = 0; ifa.S_AXI_WVALID = 0;
    ifa.S_AXI_ARADDR = 0; ifa.S_AXI_ARVALID = 0; ifa.S_AXI_BREADY = 1; ifa.S_AXI_RREADY = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_drive", 32'(drv_a), 32'h0);
    check("rst_gate", 32'(gate_a), 32'h0);
    check("rst_awready", 32'(ifa.S_AXI_AWREADY), 32'h0);
    check("rst_bvalid", 32'(ifa.S_AXI_BVALID), 32'h0);
    check("rst_rvalid", 32'(ifa.S_AXI_RVALID), 32'h0);
    @(posedge clk);
    #1 rst = 0;
    rd(32'h8, d); check("rst_status", d, 32'h0);
    rd(32'h4, d); check("rst_target", d, 32'h0);
    // verified switch with loopback
    loop = 1;
    wr(32'h4, 32'hA, t);
    rd(32'h4, d); check("target_rb", d, 32'hA);
    n0 = na; rst_cyc = -1; on_cyc = -1; done_cyc = -1; bdone_cyc = -1;
    wr(32'h0, 32'h1, t);
    wait_done(n0);
    check("t1_common_rst_lat", 32'(rst_cyc - t), 32'd1);
    check("t1_switch_on_lat", 32'(on_cyc - t), 32'd2);
    check("t1_drive_at_on", 32'(on_drv), 32'hA);
    check("t1_done_lat", 32'(done_cyc - t), 32'd8);
    check("t1_settle0_done_lat", 32'(bdone_cyc - t), 32'(BEXP));
    rd(32'h8, d); check("t1_status", d, 32'h0102);
    check("t1_gate", 32'(gate_a), 32'h1);
    rd(32'hC, d); check("t1_osw_reg", d, 32'hA);
    // timeout with stuck feedback
    loop = 0;
    wr(32'h4, 32'h5, t);
    n0 = na;
    wr(32'h0, 32'h1, t);
    repeat (30) @(negedge clk);
    check("t2_no_done", 32'(na), 32'(n0));
    rd(32'h8, d); check("t2_status", d, 32'h0104);
    check("t2_gate", 32'(gate_a), 32'h0);
    check("t2_drive", 32'(drv_a), 32'h5);
    // abort during settle
    loop = 1;
    wr(32'h4, 32'h3, t);
    n0 = na;
    wr(32'h0, 32'h1, t0);
    @(posedge clk);
    #1;
    wr(32'h0, 32'h2, t1);
    check("t3_abort_in_settle", 32'(t1 - t0), 32'd3);
    repeat (20) @(negedge clk);
    check("t3_no_done", 32'(na), 32'(n0));
    rd(32'h8, d); check("t3_status", d, 32'h0100);
    check("t3_drive", 32'(drv_a), 32'h3);
    check("t3_gate", 32'(gate_a), 32'h0);
    // restart while busy, target write while busy, then START+ABORT in idle
    n0 = na; done_cyc = -1;
    wr(32'h0, 32'h1, t0);
    wr(32'h0, 32'h1, t1);
    wr(32'h4, 32'hC, t);
    wait_done(n0);
    check("t4_done_lat", 32'(done_cyc - t0), 32'd8);
    check("t4_drive", 32'(drv_a), 32'h3);
    rd(32'h4, d); check("t4_target", d, 32'hC);
    rst_cyc = -1;
    wr(32'h0, 32'h3, t);
    repeat (20) @(negedge clk);
    check("t4_one_done", 32'(na), 32'(n0 + 1));
    check("t4_no_restart", 32'(rst_cyc), 32'hFFFFFFFF);
    rd(32'h8, d); check("t4_status", d, 32'h0202);
    // reset during CHECK
    loop = 0;
    wr(32'h0, 32'h1, t);
    repeat (8) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("t5_drive", 32'(drv_a), 32'h0);
    check("t5_gate", 32'(gate_a), 32'h0);
    check("t5_common_rst", 32'(crst_a), 32'h0);
    check("t5_switch_on", 32'(on_a), 32'h0);
    check("t5_switch_done", 32'(done_a), 32'h0);
    check("t5_bvalid", 32'(ifa.S_AXI_BVALID), 32'h0);
    rd(32'h4, d); check("t5_target", d, 32'h0);
    rd(32'h8, d); check("t5_status", d, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
